// File: rtl/demux1_4_seq_pkg.sv
// Shared definitions for the sequential 1-to-4 demultiplexer.
package demux1_4_seq_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } demux_state_e;

endpackage

// File: rtl/demux1_4_seq_if.sv
// Data/control bundle between the demux and its producer/consumer.
interface demux1_4_seq_if #(
  parameter int unsigned WIDTH = 2
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [1:0]       sel;
  logic             auto_mode;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic [3:0]       o_strobe;
  logic             frame_done;
  logic [1:0]       ch_ptr;

  modport master (
    output din, din_valid, sel, auto_mode,
    input  o0, o1, o2, o3, o_strobe, frame_done, ch_ptr
  );

  modport slave (
    input  din, din_valid, sel, auto_mode,
    output o0, o1, o2, o3, o_strobe, frame_done, ch_ptr
  );

endinterface

// File: rtl/demux_dec2_4.sv
// Combinational 2-to-4 one-hot decoder with enable; drives write enables.
module demux_dec2_4
  import demux1_4_seq_pkg::*;
(
  input  logic              en,
  input  logic [1:0]        sel,
  output logic [NUM_CH-1:0] onehot
);

  // One bit set at the selected index when enabled, otherwise all clear
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1_4_seq.sv
// Sequential 1-to-4 demultiplexer with manual/round-robin channel selection
// and frame-completion tracking over all four channels.
module demux1_4_seq
  import demux1_4_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input logic           clk,
  input logic           rst,
  demux1_4_seq_if.slave bus
);

  demux_state_e      state_q;
  logic              auto_q;
  logic [NUM_CH-1:0] mask_q;
  logic [1:0]        ptr_q;
  logic [WIDTH-1:0]  o0_q, o1_q, o2_q, o3_q;
  logic [NUM_CH-1:0] strobe_q;
  logic              frame_done_q;

  logic              mode_chg;
  logic [NUM_CH-1:0] base_mask;
  logic [1:0]        base_ptr;
  logic [1:0]        target;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] next_mask;

  // A mode change wipes frame progress before this cycle's write is applied,
  // so the write is evaluated against the cleared mask/pointer.
  always_comb begin
    mode_chg  = (bus.auto_mode != auto_q);
    base_mask = (mode_chg || state_q == IDLE) ? '0 : mask_q;
    base_ptr  = mode_chg ? '0 : ptr_q;
    target    = bus.auto_mode ? base_ptr : bus.sel;
    next_mask = base_mask | wr_en;
  end

  demux_dec2_4 u_dec (
    .en     (bus.din_valid),
    .sel    (target),
    .onehot (wr_en)
  );

  // Frame FSM, channel registers, pointer and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      auto_q       <= 1'b0;
      mask_q       <= '0;
      ptr_q        <= '0;
      o0_q         <= '0;
      o1_q         <= '0;
      o2_q         <= '0;
      o3_q         <= '0;
      strobe_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      auto_q       <= bus.auto_mode;
      strobe_q     <= wr_en;
      frame_done_q <= 1'b0;
      if (wr_en[0]) o0_q <= bus.din;
      if (wr_en[1]) o1_q <= bus.din;
      if (wr_en[2]) o2_q <= bus.din;
      if (wr_en[3]) o3_q <= bus.din;
      if (bus.din_valid) begin
        if (&next_mask) begin
          frame_done_q <= 1'b1;
          mask_q       <= '0;
          state_q      <= IDLE;
        end else begin
          mask_q  <= next_mask;
          state_q <= FILL;
        end
      end else begin
        mask_q  <= base_mask;
        state_q <= (base_mask == '0) ? IDLE : FILL;
      end
      if (!bus.auto_mode) begin
        ptr_q <= '0;
      end else if (bus.din_valid) begin
        ptr_q <= 2'(base_ptr + 2'd1);
      end else begin
        ptr_q <= base_ptr;
      end
    end
  end

  assign bus.o0         = o0_q;
  assign bus.o1         = o1_q;
  assign bus.o2         = o2_q;
  assign bus.o3         = o3_q;
  assign bus.o_strobe   = strobe_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ch_ptr     = ptr_q;

endmodule

// File: tb/tb_demux1_4_seq.sv
// Self-checking bench for demux1_4_seq: directed scenarios plus random
// traffic, compared against a behavioural channel/frame model.
module tb_demux1_4_seq;

  localparam int unsigned WIDTH = 2;

  logic clk = 1'b0;
  logic rst;

  demux1_4_seq_if #(.WIDTH(WIDTH)) bus ();

  demux1_4_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_out [4];
  bit m_written [4];
  int m_ptr;
  bit m_auto;
  int m_strobe;
  bit m_fd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int d, input int s, input bit a);
    int k;
    int cnt;
    m_strobe = 0;
    m_fd     = 1'b0;
    if (r) begin
      foreach (m_out[i]) begin
        m_out[i]     = 0;
        m_written[i] = 1'b0;
      end
      m_ptr  = 0;
      m_auto = 1'b0;
      return;
    end
    if (a != m_auto) begin
      foreach (m_written[i]) m_written[i] = 1'b0;
      m_ptr = 0;
    end
    m_auto = a;
    if (v) begin
      k            = a ? m_ptr : s;
      m_out[k]     = d;
      m_strobe     = 1 << k;
      m_written[k] = 1'b1;
      cnt = 0;
      foreach (m_written[i]) if (m_written[i]) cnt++;
      if (cnt == 4) begin
        m_fd = 1'b1;
        foreach (m_written[i]) m_written[i] = 1'b0;
      end
      if (a) m_ptr = (m_ptr + 1) % 4;
    end
    if (!a) m_ptr = 0;
  endtask

  task automatic compare_all();
    check_eq("o0", 32'(bus.o0), 32'(m_out[0]));
    check_eq("o1", 32'(bus.o1), 32'(m_out[1]));
    check_eq("o2", 32'(bus.o2), 32'(m_out[2]));
    check_eq("o3", 32'(bus.o3), 32'(m_out[3]));
    check_eq("o_strobe", 32'(bus.o_strobe), 32'(m_strobe));
    check_eq("frame_done", 32'(bus.frame_done), 32'(m_fd));
    check_eq("ch_ptr", 32'(bus.ch_ptr), 32'(m_ptr));
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rising edge
  task automatic step(input bit r, input bit v, input int d, input int s, input bit a);
    @(negedge clk);
    rst           = r;
    bus.din_valid = v;
    bus.din       = WIDTH'(d);
    bus.sel       = 2'(s);
    bus.auto_mode = a;
    @(posedge clk);
    #1;
    model_step(r, v, d, s, a);
    compare_all();
  endtask

  initial begin
    int dseq [4];
    int sseq [5];
    int mseq [5];
    bit r;
    bit v;
    bit a;

    rst           = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.sel       = '0;
    bus.auto_mode = 1'b0;
    m_auto        = 1'b0;
    m_ptr         = 0;
    foreach (m_out[i]) begin
      m_out[i]     = 0;
      m_written[i] = 1'b0;
    end

    // Reset with a write presented: discarded
    step(1, 1, 3, 0, 0);
    step(1, 1, 3, 0, 0);
    check_eq("rst_o0", 32'(bus.o0), 32'd0);
    check_eq("rst_strobe", 32'(bus.o_strobe), 32'd0);

    // Auto frame
    dseq = '{1, 2, 3, 1};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, dseq[i], 0, 1);
      check_eq("auto_ptr", 32'(bus.ch_ptr), 32'((i + 1) % 4));
      check_eq("auto_fd", 32'(bus.frame_done), 32'(i == 3));
    end
    check_eq("auto_o2", 32'(bus.o2), 32'd3);
    check_eq("auto_o3", 32'(bus.o3), 32'd1);

    // Manual out-of-order with a repeated channel
    sseq = '{2, 0, 0, 3, 1};
    mseq = '{2, 1, 3, 2, 1};
    for (int i = 0; i < 5; i++) begin
      step(0, 1, mseq[i], sseq[i], 0);
      check_eq("man_fd", 32'(bus.frame_done), 32'(i == 4));
    end
    check_eq("man_o0", 32'(bus.o0), 32'd3);

    // Auto with gaps
    step(0, 1, 2, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    check_eq("gap_ptr", 32'(bus.ch_ptr), 32'd2);

    // Mode change mid-frame
    step(0, 1, 0, 0, 1);
    step(0, 1, 3, 0, 1);
    step(0, 1, 2, 3, 0);
    check_eq("mc_o3", 32'(bus.o3), 32'd2);
    check_eq("mc_ptr", 32'(bus.ch_ptr), 32'd0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    check_eq("mc_fd_early", 32'(bus.frame_done), 32'd0);
    step(0, 1, 1, 2, 0);
    check_eq("mc_fd", 32'(bus.frame_done), 32'd1);

    // Reset mid-frame
    step(0, 1, 1, 0, 1);
    step(0, 1, 2, 0, 1);
    step(0, 1, 3, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    check_eq("rmf_o0", 32'(bus.o0), 32'd1);
    check_eq("rmf_o1", 32'(bus.o1), 32'd0);
    check_eq("rmf_ptr", 32'(bus.ch_ptr), 32'd1);
    check_eq("rmf_fd", 32'(bus.frame_done), 32'd0);

    // Random traffic
    a = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) a = ~a;
      step(r, v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
